// File: rtl/disp_pkg.sv
// Shared digit codes, FSM state and grant encodings for the display sequencer.
package disp_pkg;

  localparam logic [4:0] CODE_R     = 5'd16;
  localparam logic [4:0] CODE_D     = 5'd17;
  localparam logic [4:0] CODE_T     = 5'd18;
  localparam logic [4:0] CODE_US    = 5'd19;
  localparam logic [4:0] CODE_DASH  = 5'd20;
  localparam logic [4:0] CODE_BLANK = 5'd31;

  localparam logic [29:0] DIGITS_DASH  = {6{CODE_DASH}};
  localparam logic [29:0] DIGITS_BLANK = {6{CODE_BLANK}};

  typedef enum logic [1:0] {
    IDLE,
    SHOW_RD,
    SHOW_WR,
    GAP
  } state_t;

  typedef enum logic {
    RD,
    WR
  } grant_t;

  // Message layout: two tag digits, then addr and data as hex nibbles.
  function automatic logic [29:0] msg_digits(input grant_t g, input logic [7:0] addr,
                                             input logic [7:0] data);
    logic [4:0] w_tag5;
    logic [4:0] w_tag4;
    w_tag5 = (g == RD) ? CODE_R : CODE_DASH;
    w_tag4 = (g == RD) ? CODE_D : CODE_T;
    return {w_tag5, w_tag4, 1'b0, addr[7:4], 1'b0, addr[3:0],
            1'b0, data[7:4], 1'b0, data[3:0]};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter, purely combinational; bit 0 = read, bit 1 = write.
module rr_arb2
  import disp_pkg::*;
(
  input  logic [1:0] i_req,
  input  grant_t     i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (i_last_grant == WR) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/hex_display_sequencer.sv
// Shares the six-digit display between read and write paths; grant visible one cycle after req.
// Requests wait in place (no ack) while a message or gap is on the display.
module hex_display_sequencer
  import disp_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 5_000_000,
  parameter int CNT_W       = $clog2(((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [7:0]  rd_addr,
  input  logic [7:0]  rd_data,
  output logic        rd_ack,
  input  logic        wr_req,
  input  logic [7:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  output logic        busy,
  output logic [29:0] digit_codes
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [29:0]       r_digits;
  logic [29:0]       w_digits_nxt;
  logic              r_rd_ack;
  logic              w_rd_ack_nxt;
  logic              r_wr_ack;
  logic              w_wr_ack_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  grant_t            r_last_grant;
  grant_t            w_last_grant_nxt;
  logic [1:0]        w_req;
  logic [1:0]        w_grant;

  assign w_req = {wr_req, rd_req};

  rr_arb2 u_arb (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_digits     <= DIGITS_DASH;
      r_rd_ack     <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_busy       <= 1'b0;
      r_last_grant <= WR;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_digits     <= w_digits_nxt;
      r_rd_ack     <= w_rd_ack_nxt;
      r_wr_ack     <= w_wr_ack_nxt;
      r_busy       <= w_busy_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant[0])      w_state_nxt = SHOW_RD;
        else if (w_grant[1]) w_state_nxt = SHOW_WR;
      end
      SHOW_RD, SHOW_WR: begin
        if (r_cnt == '0) w_state_nxt = GAP;
      end
      GAP: begin
        if (r_cnt == '0) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Requests are only looked at in IDLE, so the ack cycle can never re-grant.
  always_comb begin
    w_cnt_nxt        = r_cnt;
    w_digits_nxt     = r_digits;
    w_rd_ack_nxt     = 1'b0;
    w_wr_ack_nxt     = 1'b0;
    w_busy_nxt       = r_busy;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      IDLE: begin
        w_digits_nxt = DIGITS_DASH;
        w_busy_nxt   = 1'b0;
        if (w_grant[0]) begin
          w_cnt_nxt        = HOLD_LOAD;
          w_digits_nxt     = msg_digits(RD, rd_addr, rd_data);
          w_rd_ack_nxt     = 1'b1;
          w_busy_nxt       = 1'b1;
          w_last_grant_nxt = RD;
        end else if (w_grant[1]) begin
          w_cnt_nxt        = HOLD_LOAD;
          w_digits_nxt     = msg_digits(WR, wr_addr, wr_data);
          w_wr_ack_nxt     = 1'b1;
          w_busy_nxt       = 1'b1;
          w_last_grant_nxt = WR;
        end
      end
      SHOW_RD, SHOW_WR: begin
        if (r_cnt == '0) begin
          w_cnt_nxt    = GAP_LOAD;
          w_digits_nxt = DIGITS_BLANK;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_digits_nxt = DIGITS_DASH;
          w_busy_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_digits_nxt = DIGITS_DASH;
        w_busy_nxt   = 1'b0;
      end
    endcase
  end

  assign rd_ack      = r_rd_ack;
  assign wr_ack      = r_wr_ack;
  assign busy        = r_busy;
  assign digit_codes = r_digits;

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Directed bench for hex_display_sequencer with HOLD_CYCLES=4, GAP_CYCLES=2; acks checked by a scoreboard monitor.
module tb_hex_display_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        rd_ack;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        busy;
  logic [29:0] digit_codes;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit rd_hold = 1'b0;

  localparam logic [29:0] DASH  = {6{5'd20}};
  localparam logic [29:0] BLANK = {6{5'd31}};

  typedef struct {
    bit          is_wr;
    logic [29:0] dig;
    int          at;
  } exp_t;

  exp_t sb[$];

  hex_display_sequencer #(
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_ack      (rd_ack),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .busy        (busy),
    .digit_codes (digit_codes)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input bit w, input logic [29:0] d, input int at);
    exp_t e;
    e.is_wr = w;
    e.dig   = d;
    e.at    = at;
    sb.push_back(e);
  endtask

  // Requester behaviour: drop req right after its ack unless told to hold it.
  task automatic step();
    @(negedge clk);
    if (rd_ack && !rd_hold) rd_req = 1'b0;
    if (wr_ack) wr_req = 1'b0;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic check_msg(input logic [29:0] exp);
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i <= 4)      check($sformatf("show_%0d", i), digit_codes, exp);
      else if (i <= 6) check($sformatf("blank_%0d", i), digit_codes, BLANK);
      else             check("dash_after", digit_codes, DASH);
      check($sformatf("busy_%0d", i), busy, (i <= 6) ? 1 : 0);
      if (i == 2) check("ack_one_cycle", {rd_ack, wr_ack}, 2'b00);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rd_ack || wr_ack) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack @cyc %0d: got rd=%0b wr=%0b expected none", cyc, rd_ack, wr_ack);
      end else begin
        e = sb.pop_front();
        check("ack_kind", {rd_ack, wr_ack}, e.is_wr ? 2'b01 : 2'b10);
        check("ack_digits", digit_codes, e.dig);
        check("ack_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1;
    rd_req = 1'b0; rd_addr = '0; rd_data = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    steps(2);
    check("rst_digits", digit_codes, DASH);
    check("rst_busy", busy, 0);
    check("rst_acks", {rd_ack, wr_ack}, 2'b00);
    rst = 1'b0;
    step();

    // Simultaneous requests after reset: read first, write 7 cycles later, then alternate.
    c = cyc;
    rd_addr = 8'h11; rd_data = 8'h22; wr_addr = 8'h33; wr_data = 8'h44;
    rd_req = 1'b1; wr_req = 1'b1;
    push(1'b0, {5'd16, 5'd17, 5'd1, 5'd1, 5'd2, 5'd2}, c + 1);
    push(1'b1, {5'd20, 5'd18, 5'd3, 5'd3, 5'd4, 5'd4}, c + 8);
    steps(9);
    rd_addr = 8'h55; rd_data = 8'h66; wr_addr = 8'h77; wr_data = 8'h88;
    rd_req = 1'b1; wr_req = 1'b1;
    push(1'b0, {5'd16, 5'd17, 5'd5, 5'd5, 5'd6, 5'd6}, c + 15);
    push(1'b1, {5'd20, 5'd18, 5'd7, 5'd7, 5'd8, 5'd8}, c + 22);
    steps(19);
    check("idle_after_pair", busy, 0);

    // Single read message, full show/gap/idle sequence.
    c = cyc;
    rd_addr = 8'h3C; rd_data = 8'hA5; rd_req = 1'b1;
    push(1'b0, {5'd16, 5'd17, 5'd3, 5'd12, 5'd10, 5'd5}, c + 1);
    check_msg({5'd16, 5'd17, 5'd3, 5'd12, 5'd10, 5'd5});

    // Single write message.
    c = cyc;
    wr_addr = 8'h01; wr_data = 8'hFF; wr_req = 1'b1;
    push(1'b1, {5'd20, 5'd18, 5'd0, 5'd1, 5'd15, 5'd15}, c + 1);
    check_msg({5'd20, 5'd18, 5'd0, 5'd1, 5'd15, 5'd15});

    // Write raised mid-read waits for IDLE; read inputs changed after capture.
    c = cyc;
    rd_addr = 8'h5A; rd_data = 8'h3C; rd_req = 1'b1;
    push(1'b0, {5'd16, 5'd17, 5'd5, 5'd10, 5'd3, 5'd12}, c + 1);
    step();
    rd_addr = 8'h00; rd_data = 8'h00;
    step();
    wr_addr = 8'h77; wr_data = 8'h88; wr_req = 1'b1;
    push(1'b1, {5'd20, 5'd18, 5'd7, 5'd7, 5'd8, 5'd8}, c + 8);
    check("latched_a", digit_codes, {5'd16, 5'd17, 5'd5, 5'd10, 5'd3, 5'd12});
    step();
    check("latched_b", digit_codes, {5'd16, 5'd17, 5'd5, 5'd10, 5'd3, 5'd12});
    check("wr_pending", wr_ack, 0);
    steps(11);
    check("idle_after_pend", busy, 0);

    // Read request never dropped: re-granted every 7 cycles.
    c = cyc;
    rd_hold = 1'b1;
    rd_addr = 8'hC3; rd_data = 8'h3C; rd_req = 1'b1;
    push(1'b0, {5'd16, 5'd17, 5'd12, 5'd3, 5'd3, 5'd12}, c + 1);
    push(1'b0, {5'd16, 5'd17, 5'd12, 5'd3, 5'd3, 5'd12}, c + 8);
    push(1'b0, {5'd16, 5'd17, 5'd12, 5'd3, 5'd3, 5'd12}, c + 15);
    steps(7);
    check("idle_between", busy, 0);
    steps(7);
    rd_hold = 1'b0;
    step();
    steps(6);
    check("idle_after_held", busy, 0);
    steps(2);

    // Reset in the middle of a message drops it immediately.
    c = cyc;
    rd_addr = 8'hE1; rd_data = 8'h2F; rd_req = 1'b1;
    push(1'b0, {5'd16, 5'd17, 5'd14, 5'd1, 5'd2, 5'd15}, c + 1);
    steps(2);
    check("pre_rst_show", digit_codes, {5'd16, 5'd17, 5'd14, 5'd1, 5'd2, 5'd15});
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("midrst_digits_%0d", i), digit_codes, DASH);
      check($sformatf("midrst_busy_%0d", i), busy, 0);
      check($sformatf("midrst_acks_%0d", i), {rd_ack, wr_ack}, 2'b00);
    end
    rst = 1'b0;
    steps(2);
    check("post_rst_digits", digit_codes, DASH);
    check("post_rst_busy", busy, 0);

    steps(2);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hex_display_sequencer.md
Name: hex_display_sequencer

Overview:
- Shares the six-digit seven-segment display between two requesters: the read path and the write path of the memory controller.
- Arbitrates round-robin between them and latches the winner's address and data.
- Drives six 5-bit digit codes, each feeding one hex-driver instance, for a fixed hold time.
- Then blanks for a gap and returns to an idle dash pattern.

Parameters:
- HOLD_CYCLES, 50_000_000, cycles a granted message stays on the display (must be >= 1).
- GAP_CYCLES, 5_000_000, blank cycles between messages (must be >= 1).
- CNT_W, $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1), width of the shared down-counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rd_req  in  1  read path requests display; held until rd_ack
- rd_addr  in  8  address to show
- rd_data  in  8  data to show
- rd_ack  out  1  one-cycle pulse: rd_addr/rd_data captured
- wr_req  in  1  write path requests display; held until wr_ack
- wr_addr  in  8  address to show
- wr_data  in  8  data to show
- wr_ack  out  1  one-cycle pulse: wr_addr/wr_data captured
- busy  out  1  high in SHOW_RD, SHOW_WR, GAP
- digit_codes  out  30  six 5-bit codes; [29:25]=digit5 (leftmost) ... [4:0]=digit0

Behaviour:
- Reset: state IDLE; digit_codes = six × 20 (dash); rd_ack = wr_ack = 0; busy = 0; counter = 0; last_grant = WR, so read wins the first tie.
- All outputs are registered; no combinational path from inputs to outputs.

States:
- IDLE: display all dashes.
  - Sample requests.
  - If exactly one req is high, grant it.
  - If both are high, grant the one opposite last_grant.
  - If none is high, stay in IDLE.
- Grant at edge n (req sampled high in IDLE):
  - At cycle n+1: state = SHOW_RD/SHOW_WR; matching ack = 1 for exactly that cycle; busy = 1.
  - Latch addr/data; update digit_codes; update last_grant; counter = HOLD_CYCLES-1.
- SHOW_RD digits, 5..0: 16 (r), 17 (d), addr[7:4], addr[3:0], data[7:4], data[3:0].
- SHOW_WR digits, 5..0: 20 (-), 18 (t), addr[7:4], addr[3:0], data[7:4], data[3:0].
- SHOW_x:
  - Counter decrements each cycle.
  - On counter == 0: next state GAP; digits = six × 31 (blank); counter = GAP_CYCLES-1.
  - Total SHOW duration is exactly HOLD_CYCLES cycles.
- GAP:
  - Counter decrements each cycle.
  - On counter == 0: next state IDLE; digits = dashes; busy = 0.
  - GAP lasts exactly GAP_CYCLES cycles.
- Requests are sampled only in IDLE. Any req raised during SHOW or GAP stays pending with no ack, and is served on the first IDLE cycle.
- The ack cycle always falls outside IDLE, so a req still high during its ack cycle cannot double-grant.
- Requesters must drop req the cycle after their ack. A req still high when IDLE is next reached is treated as a new request.
- Latched addr/data are immune to input changes after capture.
- Minimum period between two grants: HOLD_CYCLES + GAP_CYCLES + 1 cycles.
- rst asserted mid-message: next cycle forces the reset state (IDLE, dashes, acks low); the pending message is dropped.

Decomposition:
- Package disp_pkg holds:
  - Code constants: CODE_R = 5'd16, CODE_D = 5'd17, CODE_T = 5'd18, CODE_US = 5'd19, CODE_DASH = 5'd20, CODE_BLANK = 5'd31.
  - State enum: IDLE, SHOW_RD, SHOW_WR, GAP.
  - Grant enum: RD, WR.
- One natural sub-module: rr_arb2, a two-requester round-robin arbiter (req[1:0], last_grant in; grant one-hot out, combinational).
- The top level holds the FSM, the counter and the digit registers, and instantiates six hexDriver externally.

Test Plan (HOLD_CYCLES = 4, GAP_CYCLES = 2):
1. Reset → digit_codes = {6{5'd20}}, busy = 0, acks 0. Hold rst 3 cycles mid-SHOW → returns to the same values the next cycle.
2. rd_req with addr = 8'h3C, data = 8'hA5 → rd_ack one cycle; digits = 16,17,3,12,10,5 for 4 cycles; then 31 × 6 for 2 cycles; then dashes; busy high for exactly 6 cycles.
3. wr_req with addr = 8'h01, data = 8'hFF → wr_ack; digits = 20,18,0,1,15,15.
4. rd_req and wr_req rise together after reset → read granted first. wr stays pending and is acked exactly 7 cycles after rd_ack. Then both high again → wr loses to rd (alternation).
5. wr_req raised in the middle of SHOW_RD → no wr_ack until the first IDLE cycle. Change rd_data after rd_ack → displayed data unchanged.
6. req held high through ack and never dropped → re-granted every 7 cycles. Checks the minimum-period timing and that no double ack occurs.
